ahfp_pipeline_scheduler: RTL and testbench

Round-robin scheduler that shares one fixed-latency, non-stallable 32-bit AHFP datapath (a `STAGES`-deep pipeline with no valid or reset of its own) among `NREQ` requesters. It accepts at most one operand per cycle, drives the datapath input, and carries a {valid, id} tag alongside the datapath. When data emerges, it routes the result back to the issuing requester. Per-requester credit counters cap the number of results in flight for each requester.

---
 rtl/ahfp_pkg.sv | 17 +
 rtl/ahfp_rr_arbiter.sv | 34 +++
 rtl/ahfp_pipeline_scheduler.sv | 124 ++++++++++++
 tb/tb_ahfp_pipeline_scheduler.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
// rtl/ahfp_pkg.sv - shared types and constants for the AHFP pipeline scheduler
package ahfp_pkg;

    localparam int AHFP_DATA_W   = 32;
    // Tag ids are stored at the widest width any legal NREQ (<= 16) needs.
    localparam int AHFP_ID_MAX_W = 4;

    function automatic int id_w(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

    typedef struct packed {
        logic                     valid;
        logic [AHFP_ID_MAX_W-1:0] id;
    } ahfp_tag_t;

endpackage

// File: rtl/ahfp_rr_arbiter.sv
// rtl/ahfp_rr_arbiter.sv - combinational round-robin arbiter starting at ptr
module ahfp_rr_arbiter
    import ahfp_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    // Each index gets a distance from ptr (mod NREQ); the eligible index
    // with the smallest distance wins. This avoids a variable-index scan.
    always_comb begin
        int best_d;
        int d;
        best_d   = NREQ;
        d        = 0;
        grant_id = '0;
        for (int j = 0; j < NREQ; j++) begin
            d = (j + NREQ - int'(ptr)) % NREQ;
            if (eligible[j] && (d < best_d)) begin
                best_d   = d;
                grant_id = ID_W'(j);
            end
        end
        any   = (best_d < NREQ);
        grant = any ? (NREQ'(1) << grant_id) : '0;
    end

endmodule

// File: rtl/ahfp_pipeline_scheduler.sv
// rtl/ahfp_pipeline_scheduler.sv - round-robin issue and result routing for a shared fixed-latency datapath
module ahfp_pipeline_scheduler
    import ahfp_pkg::*;
#(
    parameter int STAGES  = 10,
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*AHFP_DATA_W-1:0] req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic [AHFP_DATA_W-1:0]      pipe_in,
    input  logic [AHFP_DATA_W-1:0]      pipe_out,
    output logic [NREQ-1:0]             res_valid,
    output logic [AHFP_DATA_W-1:0]      res_data,
    output logic                        busy
);

    localparam int ID_W  = id_w(NREQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [ID_W-1:0]        ptr;
    logic [CNT_W-1:0]       outstanding [NREQ];
    logic [NREQ-1:0]        eligible;
    logic [NREQ-1:0]        grant;
    logic [ID_W-1:0]        grant_id;
    logic                   any;
    logic [AHFP_DATA_W-1:0] req_lane [NREQ];
    ahfp_tag_t              issue_tag;
    ahfp_tag_t              last_tag;

    // Eligibility uses the pre-update credit count, so a full requester is
    // never granted even when one of its results retires this cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = !rst && req_valid[i] && (outstanding[i] < CNT_W'(MAX_OUT));
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign req_lane[i] = req_data[AHFP_DATA_W*i +: AHFP_DATA_W];
    end

    ahfp_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .eligible(eligible),
        .ptr     (ptr),
        .grant   (grant),
        .grant_id(grant_id),
        .any     (any)
    );

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // Issue register: the tag travelling with pipe_in, then STAGES tag
    // stages so the last stage lines up with pipe_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_in   <= '0;
            issue_tag <= '0;
        end else begin
            pipe_in         <= any ? req_lane[grant_id] : '0;
            issue_tag.valid <= any;
            issue_tag.id    <= AHFP_ID_MAX_W'(grant_id);
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_tag
        ahfp_tag_t q;
        logic      any_v;
        if (s == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) q <= '0;
                else     q <= issue_tag;
            end
            assign any_v = q.valid | issue_tag.valid;
        end else begin : g_rest
            always_ff @(posedge clk) begin
                if (rst) q <= '0;
                else     q <= g_tag[s-1].q;
            end
            assign any_v = q.valid | g_tag[s-1].any_v;
        end
    end

    assign last_tag = g_tag[STAGES-1].q;
    assign busy     = g_tag[STAGES-1].any_v;
    assign res_data = pipe_out;

    always_comb begin
        res_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            res_valid[i] = last_tag.valid && (last_tag.id == AHFP_ID_MAX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                outstanding[i] <= '0;
            end else begin
                assert (!(res_valid[i] && !grant[i] && (outstanding[i] == '0)));
                if (grant[i] && !res_valid[i]) begin
                    outstanding[i] <= outstanding[i] + CNT_W'(1);
                end else if (!grant[i] && res_valid[i]) begin
                    outstanding[i] <= outstanding[i] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ahfp_pipeline_scheduler.sv
// tb/tb_ahfp_pipeline_scheduler.sv - randomized model-checked bench for ahfp_pipeline_scheduler
module tb_ahfp_pipeline_scheduler;

    localparam int STAGES  = 10;
    localparam int NREQ    = 4;
    localparam int MAX_OUT = 4;
    localparam int LAT     = STAGES + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req_valid = '0;
    logic [127:0]   req_data  = '0;
    logic [3:0]     req_ready;
    logic [31:0]    pipe_in;
    logic [31:0]    pipe_out;
    logic [3:0]     res_valid;
    logic [31:0]    res_data;
    logic           busy;

    logic [31:0]    dl [STAGES];
    logic           use_rand = 1'b0;
    logic [31:0]    rand_po  = '0;

    always #5 clk = ~clk;

    ahfp_pipeline_scheduler #(
        .STAGES (STAGES),
        .NREQ   (NREQ),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .pipe_in  (pipe_in),
        .pipe_out (pipe_out),
        .res_valid(res_valid),
        .res_data (res_data),
        .busy     (busy)
    );

    // Identity datapath: STAGES cycles of pure delay.
    always @(posedge clk) begin
        dl[0] <= pipe_in;
        for (int k = 1; k < STAGES; k++) dl[k] <= dl[k-1];
    end
    assign pipe_out = use_rand ? rand_po : dl[STAGES-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: credit counts, pointer, and a list of pending results.
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } ent_t;

    ent_t        pend [$];
    int          cnt [NREQ];
    int          mptr = 0;
    int          exp_gnt;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rv;
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic [31:0] exp_pin = '0;

    task automatic model_eval();
        int idx;
        exp_gnt = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (exp_gnt < 0 && !rst && req_valid[idx] && cnt[idx] < MAX_OUT) exp_gnt = idx;
        end
        exp_ready = (exp_gnt >= 0) ? (4'd1 << exp_gnt) : 4'd0;
        exp_rv   = '0;
        exp_rd   = '0;
        exp_busy = 1'b0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                exp_rv = exp_rv | (4'd1 << pend[i].id);
                exp_rd = pend[i].data;
            end
            if (pend[i].due - STAGES <= cyc) exp_busy = 1'b1;
        end
    endtask

    task automatic model_commit();
        ent_t e;
        if (rst) begin
            pend.delete();
            foreach (cnt[i]) cnt[i] = 0;
            mptr    = 0;
            exp_pin = '0;
        end else begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    cnt[pend[i].id]--;
                    pend.delete(i);
                end
            end
            if (exp_gnt >= 0) begin
                e.due  = cyc + LAT;
                e.id   = exp_gnt;
                e.data = req_data[exp_gnt*32 +: 32];
                pend.push_back(e);
                cnt[exp_gnt]++;
                mptr    = (exp_gnt + 1) % NREQ;
                exp_pin = e.data;
            end else begin
                exp_pin = '0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        use_rand = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_po = $urandom;
            settle();
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL reset_ready cyc=%0d got=%b exp=0000", cyc, req_ready);
            end
            advance();
        end
        rst = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            rand_po = $urandom;
            settle();
            checks++;
            if (res_valid !== 4'b0000) begin
                failures++;
                $display("FAIL reset_res_valid cyc=%0d got=%b exp=0000", cyc, res_valid);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy cyc=%0d got=%b exp=0", cyc, busy);
            end
            checks++;
            if (pipe_in !== 32'h0) begin
                failures++;
                $display("FAIL reset_pipe_in cyc=%0d got=%h exp=0", cyc, pipe_in);
            end
            advance();
        end
        use_rand = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k <= LAT + 3; k++) begin
            req_valid = (k == 0) ? 4'b0100 : 4'b0000;
            req_data[2*32 +: 32] = (k == 0) ? 32'h3F80_0000 : $urandom;
            settle();
            if (k == 0) begin
                checks++;
                if (req_ready !== 4'b0100) begin
                    failures++;
                    $display("FAIL single_ready got=%b exp=0100", req_ready);
                end
            end
            if (k == 1) begin
                checks++;
                if (pipe_in !== 32'h3F80_0000) begin
                    failures++;
                    $display("FAIL single_pipe_in got=%h exp=3f800000", pipe_in);
                end
            end
            checks++;
            if (res_valid !== ((k == LAT) ? 4'b0100 : 4'b0000)) begin
                failures++;
                $display("FAIL single_res_valid k=%0d got=%b", k, res_valid);
            end
            if (k == LAT) begin
                checks++;
                if (res_data !== 32'h3F80_0000) begin
                    failures++;
                    $display("FAIL single_res_data got=%h exp=3f800000", res_data);
                end
            end
            advance();
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            req_valid = (k < 16) ? 4'hF : 4'h0;
            req_data = {$urandom, $urandom, $urandom, $urandom};
            settle();
            if (k < 16) begin
                checks++;
                if (req_ready !== (4'd1 << (k % 4))) begin
                    failures++;
                    $display("FAIL fair_order k=%0d got=%b exp_id=%0d", k, req_ready, k % 4);
                end
            end
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL fair_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready);
            end
            checks++;
            if (res_valid !== exp_rv) begin
                failures++;
                $display("FAIL fair_res_valid k=%0d got=%b exp=%b", k, res_valid, exp_rv);
            end
            if (exp_rv != 0) begin
                checks++;
                if (res_data !== exp_rd) begin
                    failures++;
                    $display("FAIL fair_res_data k=%0d got=%h exp=%h", k, res_data, exp_rd);
                end
            end
            advance();
        end
    endtask

    task automatic test_credit();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            req_valid = (k < 24) ? 4'b0010 : 4'b0000;
            req_data = {$urandom, $urandom, $urandom, $urandom};
            settle();
            if (k <= 10) begin
                checks++;
                if (req_ready !== ((k < 4) ? 4'b0010 : 4'b0000)) begin
                    failures++;
                    $display("FAIL credit_ready k=%0d got=%b", k, req_ready);
                end
            end
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL credit_model_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready);
            end
            checks++;
            if (res_valid !== exp_rv || busy !== exp_busy) begin
                failures++;
                $display("FAIL credit_res k=%0d got=%b/%b exp=%b/%b", k, res_valid, busy, exp_rv, exp_busy);
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        logic [3:0] pat [3];
        pat[0] = 4'b0001;
        pat[1] = 4'b0010;
        pat[2] = 4'b1000;
        do_reset();
        for (int k = 0; k < 26; k++) begin
            req_valid = (k < 3) ? pat[k] : 4'b0000;
            req_data = {$urandom, $urandom, $urandom, $urandom};
            rst = (k == 5);
            settle();
            if (k < 3) begin
                checks++;
                if (req_ready !== pat[k]) begin
                    failures++;
                    $display("FAIL mid_accept k=%0d got=%b exp=%b", k, req_ready, pat[k]);
                end
            end
            if (k > 5) begin
                checks++;
                if (res_valid !== 4'b0000 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_dropped k=%0d got=%b/%b exp=0000/0", k, res_valid, busy);
                end
            end
            advance();
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            req_valid = (k < 6) ? 4'b0001 : 4'b0000;
            req_data = {$urandom, $urandom, $urandom, $urandom};
            settle();
            if (k < 6) begin
                checks++;
                if (req_ready !== ((k < 4) ? 4'b0001 : 4'b0000)) begin
                    failures++;
                    $display("FAIL mid_after_ready k=%0d got=%b", k, req_ready);
                end
            end
            checks++;
            if (res_valid !== exp_rv) begin
                failures++;
                $display("FAIL mid_after_res k=%0d got=%b exp=%b", k, res_valid, exp_rv);
            end
            advance();
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        for (int k = 0; k < 18; k++) begin
            req_valid = (k < 4 && (k % 2 == 0)) ? 4'b0001 : 4'b0000;
            req_data = {$urandom, $urandom, $urandom, $urandom};
            if (k == 0) req_data[31:0] = 32'd1;
            if (k == 2) req_data[31:0] = 32'd2;
            settle();
            if (k >= 1 && k <= 4) begin
                checks++;
                if (pipe_in !== ((k == 1) ? 32'd1 : (k == 3) ? 32'd2 : 32'd0)) begin
                    failures++;
                    $display("FAIL bubble_pipe_in k=%0d got=%h", k, pipe_in);
                end
            end
            checks++;
            if (res_valid !== ((k == LAT || k == LAT + 2) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL bubble_res_valid k=%0d got=%b", k, res_valid);
            end
            if (k == LAT || k == LAT + 2) begin
                checks++;
                if (res_data !== ((k == LAT) ? 32'd1 : 32'd2)) begin
                    failures++;
                    $display("FAIL bubble_res_data k=%0d got=%h", k, res_data);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 500; k++) begin
            req_valid = 4'($urandom);
            req_data = {$urandom, $urandom, $urandom, $urandom};
            rst = ($urandom_range(0, 79) == 0);
            settle();
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
            end
            checks++;
            if (res_valid !== exp_rv) begin
                failures++;
                $display("FAIL rand_res_valid cyc=%0d got=%b exp=%b", cyc, res_valid, exp_rv);
            end
            if (exp_rv != 0) begin
                checks++;
                if (res_data !== exp_rd) begin
                    failures++;
                    $display("FAIL rand_res_data cyc=%0d got=%h exp=%h", cyc, res_data, exp_rd);
                end
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
            end
            checks++;
            if (pipe_in !== exp_pin) begin
                failures++;
                $display("FAIL rand_pipe_in cyc=%0d got=%h exp=%h", cyc, pipe_in, exp_pin);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        foreach (cnt[i]) cnt[i] = 0;
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_credit();
        test_reset_midflight();
        test_bubbles();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
